instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit microcontroller datapath. It fetches instructions over a request/ready handshake and latches them into the IR. It decodes the opcode and issues one cycle of datapath strobes per instruction (PC, IR, register file, ACC, ALU select). It resolves conditional jumps on the Z/C flags, supports run/pause gating, halts on HLT, and faults on a fetch timeout.

Parameters:
MEM_WAIT_MAX, 15, maximum FETCH cycles without MemRdy before entering FAULT (1..255).

Ports:
CLK  input  1  clock, all state changes on rising edge.
CLB  input  1  reset, synchronous, active-high.
Run  input  1  1 = keep sequencing; 0 = pause in IDLE after the current instruction.
MemRdy  input  1  program memory has instruction data valid this cycle.
Opcode  input  8  IR contents: [7:4] op class, [3:0] register index / immediate.
Z  input  1  ACC zero flag.
C  input  1  ALU carry flag.
MemReq  output  1  instruction fetch request.
LoadIR  output  1  IR load strobe.
IncPC  output  1  PC increment strobe.
SelPC  output  1  PC load source: 0 = register, 1 = immediate.
LoadPC  output  1  PC load strobe.
LoadReg  output  1  register file write strobe (from ACC).
LoadAcc  output  1  ACC load strobe.
SelAcc  output  2  ACC source: 00 zero, 01 immediate, 10 ALU.
SelALU  output  4  ALU op: 0000 pass, 0010 add, 0011 sub, 0100 nor.
Halted  output  1  high while in HALT.
Fault  output  1  high while in FAULT.
IllegalOp  output  1  one-cycle pulse in EXEC for an undefined opcode.

Behaviour:
- Reset: CLB high at a rising edge puts the FSM in IDLE and drives all outputs 0. Reset mid-fetch or mid-exec aborts immediately with no strobe in the following cycle.
- Outputs are Moore: a function of the current state, the opcode latched in DECODE, and the latched condition bit. They are never a function of live Z/C/MemRdy.
- IDLE: all strobes 0. Run=1 moves to FETCH on the next cycle.
- FETCH: MemReq=1. Wait counter starts at 0 on entry and increments each cycle MemRdy=0.
  - MemRdy=1: LoadIR=1 and IncPC=1 in that same cycle (combinational on state only; the strobe is taken with the ready cycle). Next state DECODE.
  - Counter reaches MEM_WAIT_MAX with MemRdy=0: next state FAULT. MemRdy on the final allowed cycle still counts as success.
- DECODE: one cycle, all strobes 0. Latch Opcode[7:4] into an internal op register. Latch taken = (Z for JZ*) or (C for JC*); for other ops taken is don't-care. Next state EXEC.
- EXEC: one cycle of strobes by op class. Unlisted signals are 0.
  - 0x0 NOP: none.
  - 0x1 ADD: SelALU=0010, SelAcc=10, LoadAcc=1.
  - 0x2 SUB: SelALU=0011, SelAcc=10, LoadAcc=1.
  - 0x3 NOR: SelALU=0100, SelAcc=10, LoadAcc=1.
  - 0x4 MOVR: SelALU=0000, SelAcc=10, LoadAcc=1.
  - 0x5 MOVA: LoadReg=1.
  - 0x6 JZR / 0x8 JCR: SelPC=0, LoadPC=taken.
  - 0x7 JZI / 0x9 JCI: SelPC=1, LoadPC=taken.
  - 0xA LDI: SelAcc=01, LoadAcc=1.
  - 0xF HLT: none, next state HALT.
  - 0xB–0xE: IllegalOp=1, otherwise treated as NOP.
- After EXEC (non-HLT): Run=1 goes to FETCH; Run=0 goes to IDLE. Run is sampled only in IDLE and at the end of EXEC; deasserting Run mid-instruction never truncates it.
- HALT: Halted=1, all strobes 0. Exits only via CLB.
- FAULT: Fault=1, all strobes 0. Exits only via CLB.
- Throughput: minimum 3 cycles per instruction (FETCH with immediate MemRdy, DECODE, EXEC). Each wait cycle adds 1.
- At most one of LoadPC/IncPC is high in any cycle. LoadAcc and LoadReg are never both high.

Test Plan:
- CLB=1 for 2 cycles, Run=1, MemRdy=1, Opcode=0x13 -> cycles after reset: IDLE, FETCH (MemReq=LoadIR=IncPC=1), DECODE (strobes 0), EXEC (SelALU=0010, SelAcc=10, LoadAcc=1), then FETCH.
- Opcode=0x75 with Z=1 at DECODE, Z=0 in EXEC -> EXEC shows SelPC=1, LoadPC=1. Repeat with Z=0 at DECODE -> LoadPC=0.
- MemRdy held 0, MEM_WAIT_MAX=15 -> MemReq high for 16 cycles, then Fault=1 with all strobes 0. Assert CLB -> IDLE with Fault=0.
- Opcode=0xF0 -> after EXEC Halted=1 permanently while Run=1 and MemRdy=1. CLB clears it.
- Opcode=0xC0 -> IllegalOp=1 for exactly 1 cycle, no LoadAcc/LoadReg/LoadPC, sequencing continues.
- Run dropped during DECODE of 0x50 -> EXEC still gives LoadReg=1, then IDLE with MemReq=0. Run=1 again -> FETCH next cycle. CLB asserted in the EXEC cycle -> next cycle all outputs 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit microcontroller datapath.
// All outputs are registered and depend only on state, latched op class and latched condition.
module instr_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       CLB,
  input  logic       Run,
  input  logic       MemRdy,
  input  logic [7:0] Opcode,
  input  logic       Z,
  input  logic       C,
  output logic       MemReq,
  output logic       LoadIR,
  output logic       IncPC,
  output logic       SelPC,
  output logic       LoadPC,
  output logic       LoadReg,
  output logic       LoadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] SelALU,
  output logic       Halted,
  output logic       Fault,
  output logic       IllegalOp
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       load_ir;
    logic       inc_pc;
    logic       sel_pc;
    logic       load_pc;
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       halted;
    logic       fault;
    logic       illegal_op;
  } ctl_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_MOVA = 4'h5;
  localparam logic [3:0] OP_JZR  = 4'h6;
  localparam logic [3:0] OP_JZI  = 4'h7;
  localparam logic [3:0] OP_JCR  = 4'h8;
  localparam logic [3:0] OP_JCI  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_t     state_r, state_s;
  logic [3:0] op_r, op_s;
  logic       taken_r, taken_s;
  logic [7:0] wait_r;
  ctl_t       ctl_r;
  logic       unused_opcode_s;

  // The low opcode nibble feeds the datapath directly and is not needed here.
  assign unused_opcode_s = ^Opcode[3:0];

  // Control strobes for a given state; EXEC decodes the latched op class.
  function automatic ctl_t decode_out(input state_t st, input logic [3:0] op, input logic taken);
    ctl_t o;
    o = '0;
    case (st)
      ST_FETCH: begin
        o.mem_req = 1'b1;
        o.load_ir = 1'b1;
        o.inc_pc  = 1'b1;
      end
      ST_EXEC: begin
        case (op)
          OP_NOP, OP_HLT: o = '0;
          OP_ADD:  begin o.sel_alu = 4'b0010; o.sel_acc = 2'b10; o.load_acc = 1'b1; end
          OP_SUB:  begin o.sel_alu = 4'b0011; o.sel_acc = 2'b10; o.load_acc = 1'b1; end
          OP_NOR:  begin o.sel_alu = 4'b0100; o.sel_acc = 2'b10; o.load_acc = 1'b1; end
          OP_MOVR: begin o.sel_alu = 4'b0000; o.sel_acc = 2'b10; o.load_acc = 1'b1; end
          OP_MOVA: o.load_reg = 1'b1;
          OP_JZR, OP_JCR: begin o.sel_pc = 1'b0; o.load_pc = taken; end
          OP_JZI, OP_JCI: begin o.sel_pc = 1'b1; o.load_pc = taken; end
          OP_LDI:  begin o.sel_acc = 2'b01; o.load_acc = 1'b1; end
          default: o.illegal_op = 1'b1;
        endcase
      end
      ST_HALT:  o.halted = 1'b1;
      ST_FAULT: o.fault = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  // Next-state logic plus the op class / condition latch taken in DECODE.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    taken_s = taken_r;
    case (state_r)
      ST_IDLE: begin
        if (Run) state_s = ST_FETCH;
        else     state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (MemRdy)                    state_s = ST_DECODE;
        else if (wait_r == WAIT_LIMIT) state_s = ST_FAULT;
        else                           state_s = ST_FETCH;
      end
      ST_DECODE: begin
        op_s    = Opcode[7:4];
        state_s = ST_EXEC;
        case (Opcode[7:4])
          OP_JZR, OP_JZI: taken_s = Z;
          OP_JCR, OP_JCI: taken_s = C;
          default:        taken_s = 1'b0;
        endcase
      end
      ST_EXEC: begin
        if (op_r == OP_HLT) state_s = ST_HALT;
        else if (Run)       state_s = ST_FETCH;
        else                state_s = ST_IDLE;
      end
      ST_HALT:  state_s = ST_HALT;
      ST_FAULT: state_s = ST_FAULT;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, latched decode and registered strobes; strobes track the state being entered.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      state_r <= ST_IDLE;
      op_r    <= 4'h0;
      taken_r <= 1'b0;
      ctl_r   <= '0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      taken_r <= taken_s;
      ctl_r   <= decode_out(state_s, op_s, taken_s);
    end
  end

  // Fetch wait counter: counts cycles without MemRdy, cleared outside FETCH.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      wait_r <= 8'd0;
    end else if (state_r == ST_FETCH && !MemRdy) begin
      wait_r <= wait_r + 8'd1;
    end else begin
      wait_r <= 8'd0;
    end
  end

  assign MemReq    = ctl_r.mem_req;
  assign LoadIR    = ctl_r.load_ir;
  assign IncPC     = ctl_r.inc_pc;
  assign SelPC     = ctl_r.sel_pc;
  assign LoadPC    = ctl_r.load_pc;
  assign LoadReg   = ctl_r.load_reg;
  assign LoadAcc   = ctl_r.load_acc;
  assign SelAcc    = ctl_r.sel_acc;
  assign SelALU    = ctl_r.sel_alu;
  assign Halted    = ctl_r.halted;
  assign Fault     = ctl_r.fault;
  assign IllegalOp = ctl_r.illegal_op;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, hand sequences, and random
// instruction streams checked against an instruction-level timeline model.
module tb_instr_sequencer;

  localparam int MAX = 15;
  localparam logic [15:0] E_IDLE  = 16'h0000;
  localparam logic [15:0] E_FETCH = 16'hE000;
  localparam logic [15:0] E_HALT  = 16'h0004;
  localparam logic [15:0] E_FAULT = 16'h0002;

  logic       CLK = 1'b0;
  logic       CLB = 1'b1;
  logic       Run = 1'b0;
  logic       MemRdy = 1'b0;
  logic [7:0] Opcode = 8'h00;
  logic       Z = 1'b0;
  logic       C = 1'b0;
  logic       MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic       Halted, Fault, IllegalOp;
  logic [15:0] outs;

  int checks = 0;
  int passed = 0;

  instr_sequencer #(.MEM_WAIT_MAX(MAX)) dut (
    .CLK(CLK), .CLB(CLB), .Run(Run), .MemRdy(MemRdy), .Opcode(Opcode), .Z(Z), .C(C),
    .MemReq(MemReq), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .Halted(Halted), .Fault(Fault), .IllegalOp(IllegalOp)
  );

  always #5 CLK = ~CLK;

  assign outs = {MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
                 Halted, Fault, IllegalOp};

  typedef struct {
    logic        clb;
    logic        run;
    logic        rdy;
    logic [7:0]  op;
    logic        z;
    logic        c;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // EXEC-cycle strobes for an op class, straight from the instruction table.
  function automatic logic [15:0] exec_exp(input logic [3:0] op, input logic z, input logic c);
    logic [15:0] e;
    e = 16'h0000;
    if (op >= 4'h1 && op <= 4'h4) begin
      e[9]   = 1'b1;
      e[8:7] = 2'b10;
      e[6:3] = (op == 4'h4) ? 4'h0 : op + 4'h1;
    end else if (op == 4'h5) begin
      e[10] = 1'b1;
    end else if (op >= 4'h6 && op <= 4'h9) begin
      e[12] = op[0];
      e[11] = (op < 4'h8) ? z : c;
    end else if (op == 4'hA) begin
      e[9]   = 1'b1;
      e[8:7] = 2'b01;
    end else if (op >= 4'hB && op <= 4'hE) begin
      e[0] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rop();
    return 8'($urandom);
  endfunction

  // Drive one cycle of inputs, then compare outputs of the cycle that follows.
  task automatic tick(input logic clb_i, input logic run_i, input logic rdy_i,
                      input logic [7:0] op_i, input logic z_i, input logic c_i,
                      input logic [15:0] exp, input string name);
    CLB = clb_i; Run = run_i; MemRdy = rdy_i; Opcode = op_i; Z = z_i; C = c_i;
    @(negedge CLK);
    checks++;
    if (outs !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, outs, exp, $time);
    else passed++;
  endtask

  task automatic do_reset();
    tick(1'b1, rb(), rb(), rop(), rb(), rb(), E_IDLE, "rst_a");
    tick(1'b1, rb(), rb(), rop(), rb(), rb(), E_IDLE, "rst_b");
  endtask

  task automatic add(input logic clb, input logic run, input logic rdy, input logic [7:0] op,
                     input logic z, input logic c, input logic [15:0] exp, input string name);
    vec_t v;
    v = '{clb, run, rdy, op, z, c, exp, name};
    tbl.push_back(v);
  endtask

  int  w;
  int  k;
  logic [3:0] op;
  logic zz, cc, run_end, rdy, faulted, in_idle;

  initial begin
    add(1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, E_IDLE,  "rst_1");
    add(1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, E_IDLE,  "rst_2");
    add(1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, E_FETCH, "fetch_add");
    add(1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, E_IDLE,  "decode_add");
    add(1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 16'h0310, "exec_add");
    add(1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b0, E_FETCH, "fetch_jzi");
    add(1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b0, E_IDLE,  "decode_jzi");
    add(1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b0, 16'h1800, "jzi_taken");
    add(1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 1'b0, E_FETCH, "fetch_jzi2");
    add(1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, E_IDLE,  "decode_jzi2");
    add(1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 1'b1, 16'h1000, "jzi_not_taken");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, E_FETCH, "fetch_ill");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_ill");
    add(1'b0, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 16'h0001, "illegal_pulse");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "illegal_cleared");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_ldi");
    add(1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 1'b0, 16'h0280, "exec_ldi");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_jci");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_jci");
    add(1'b0, 1'b1, 1'b1, 8'h93, 1'b0, 1'b1, 16'h1800, "jci_taken");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_jcr");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_jcr");
    add(1'b0, 1'b1, 1'b1, 8'h84, 1'b0, 1'b1, 16'h0800, "jcr_taken");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_mova");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_mova");
    add(1'b0, 1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 16'h0400, "mova_run_drop");
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "idle_after");
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "idle_hold");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "run_resume");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_sub");
    add(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 16'h0318, "exec_sub");
    add(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "rst_in_exec");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_nor");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_nor");
    add(1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0, 16'h0320, "exec_nor");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_movr");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_movr");
    add(1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 16'h0300, "exec_movr");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_nop");
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_nop");
    add(1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, E_IDLE,  "exec_nop");
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "nop_to_idle");

    foreach (tbl[i]) tick(tbl[i].clb, tbl[i].run, tbl[i].rdy, tbl[i].op, tbl[i].z, tbl[i].c,
                          tbl[i].exp, tbl[i].name);

    // HLT: halted forever under Run=1/MemRdy=1 until reset.
    tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_hlt");
    tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "decode_hlt");
    tick(1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, E_IDLE,  "exec_hlt");
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, E_HALT, "halted");
    tick(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE, "halt_cleared");
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, E_IDLE, "idle_after_halt");

    // Fetch timeout: 16 FETCH cycles then FAULT, sticky until reset.
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, E_FETCH, "fetch_wait_0");
    for (int i = 0; i <= MAX; i++)
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, (i == MAX) ? E_FAULT : E_FETCH, "fetch_wait");
    tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FAULT, "fault_hold_1");
    tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_FAULT, "fault_hold_2");
    tick(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, E_IDLE,  "fault_cleared");

    // Random instruction streams against an instruction-level timeline model.
    in_idle = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (in_idle) begin
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) tick(1'b0, 1'b0, rb(), rop(), rb(), rb(), E_IDLE, "r_idle");
        tick(1'b0, 1'b1, rb(), rop(), rb(), rb(), E_FETCH, "r_start");
      end
      if (n == 0)      w = MAX;
      else if (n == 1) w = MAX + 1;
      else if ($urandom_range(0, 9) == 0) w = $urandom_range(4, MAX + 1);
      else             w = $urandom_range(0, 3);
      faulted = 1'b0;
      for (int i = 0; i <= MAX; i++) begin
        rdy = (i == w);
        tick(1'b0, rb(), rdy, rop(), rb(), rb(),
             rdy ? E_IDLE : ((i == MAX) ? E_FAULT : E_FETCH), "r_fetch");
        if (rdy) break;
        if (i == MAX) faulted = 1'b1;
      end
      if (faulted) begin
        tick(1'b0, 1'b1, 1'b1, rop(), rb(), rb(), E_FAULT, "r_fault_hold");
        do_reset();
        in_idle = 1'b1;
        continue;
      end
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 2) != 0) op = 4'h1;
      zz = rb();
      cc = rb();
      tick(1'b0, rb(), rb(), {op, 4'($urandom)}, zz, cc, exec_exp(op, zz, cc), "r_exec");
      run_end = ($urandom_range(0, 3) != 0);
      if (op == 4'hF) begin
        tick(1'b0, run_end, rb(), rop(), rb(), rb(), E_HALT, "r_halt");
        tick(1'b0, 1'b1, 1'b1, rop(), rb(), rb(), E_HALT, "r_halt_hold");
        do_reset();
        in_idle = 1'b1;
        continue;
      end
      tick(1'b0, run_end, rb(), rop(), rb(), rb(), run_end ? E_FETCH : E_IDLE, "r_after_exec");
      in_idle = !run_end;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
